// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types, saturation and weight-seed helpers for the training neuron
package neuron_pkg;

  typedef enum logic [2:0] {IDLE, FWD, RES, ERR, BWD, PRP} state_t;

  // Wide signed working type; every intermediate sum/product fits before saturation
  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Sequencer index must reach 2*n (backward pass issues two products per input plus a drain)
  function automatic int idx_bits(input int n);
    return $clog2(2 * n + 1);
  endfunction

  // Forward accumulator: full product width plus growth for n terms
  function automatic int acc_bits(input int w, input int n);
    return 2 * w + $clog2(n);
  endfunction

  // Clamp to the signed range of a w-bit value
  function automatic calc_t sat(input calc_t v, input int w);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    lo = -(calc_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  // 16-bit Fibonacci LFSR stepped idx+1 times from the seed; seed 0 stays 0
  function automatic logic [15:0] seed_weight(input int seed, input int idx);
    logic [15:0] lfsr;
    lfsr = 16'(seed);
    for (int k = 0; k <= idx; k++) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    return lfsr;
  endfunction

endpackage

// File: rtl/neuron_mac_mul.sv
// rtl/neuron_mac_mul.sv - registered signed W x W multiplier shared by forward and backward passes
module neuron_mac_mul #(
  parameter int W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] p
);

  // One-cycle product register; operands widened first so the full product is kept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) p <= '0;
    else        p <= (2*W)'(a) * (2*W)'(b);
  end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - N-input training neuron, one shared multiplier; optional ReLU via NEURON_MAC_RELU_EN
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int N    = 2,
  parameter int A    = 8,
  parameter int W    = 16,
  parameter int RATE = 0,
  parameter int SEED = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  train,
  input  logic                  argument_valid,
  output logic                  argument_ready,
  input  logic [N-1:0][A-1:0]   argument_data,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic signed [W-1:0]   result_data,
  input  logic                  error_valid,
  output logic                  error_ready,
  input  logic signed [W-1:0]   error_data,
  output logic                  propagate_valid,
  input  logic                  propagate_ready,
  output logic [N-1:0][W-1:0]   propagate_data
);

  localparam int IDX_W = idx_bits(N);
  localparam int ACC_W = acc_bits(W, N);

  state_t                     state;
  logic [IDX_W-1:0]           idx;
  logic [N-1:0][A-1:0]        args_q;
  logic signed [W-1:0]        err_q;
  logic signed [W-1:0]        w [N];
  logic signed [W-1:0]        bias;
  logic signed [ACC_W-1:0]    acc;
  logic [N-1:0][W-1:0]        prop_q;
  logic signed [W-1:0]        mul_a;
  logic signed [W-1:0]        mul_b;
  logic signed [2*W-1:0]      mul_p;
  calc_t                      sum_c;
  logic signed [W-1:0]        pre_c;
  logic signed [W-1:0]        res_c;
`ifdef NEURON_MAC_RELU_EN
  logic signed [W-1:0]        pre_q;
`endif

  assign propagate_data = prop_q;

  neuron_mac_mul #(.W(W)) u_mul (
    .clock (clock),
    .reset (reset),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  // Multiplier operand select: FWD issues w[i]*arg[i]; BWD issues err*w[i] then err*arg[i]
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int i = 0; i < N; i++) begin
      if (state == FWD && idx == IDX_W'(i)) begin
        mul_a = w[i];
        mul_b = W'(args_q[i]);
      end
      if (state == BWD && idx == IDX_W'(2 * i)) begin
        mul_a = err_q;
        mul_b = w[i];
      end
      if (state == BWD && idx == IDX_W'(2 * i + 1)) begin
        mul_a = err_q;
        mul_b = W'(args_q[i]);
      end
    end
  end

  // Final forward value: last product folded in, scaled, saturated, bias added and saturated again
  always_comb begin
    sum_c = (calc_t'(acc) + calc_t'(mul_p)) >>> A;
    pre_c = W'(sat(sat(sum_c, W) + calc_t'(bias), W));
`ifdef NEURON_MAC_RELU_EN
    res_c = pre_c[W-1] ? '0 : pre_c;
`else
    res_c = pre_c;
`endif
  end

  // Transaction sequencer: products arrive one cycle after issue, so each pass ends with a drain step
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      idx             <= '0;
      args_q          <= '0;
      err_q           <= '0;
      acc             <= '0;
      prop_q          <= '0;
      result_data     <= '0;
      result_valid    <= 1'b0;
      argument_ready  <= 1'b0;
      error_ready     <= 1'b0;
      propagate_valid <= 1'b0;
      for (int i = 0; i < N; i++) w[i] <= W'($signed(seed_weight(SEED, i)));
      bias            <= W'($signed(seed_weight(SEED, N)));
`ifdef NEURON_MAC_RELU_EN
      pre_q           <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (argument_ready && argument_valid) begin
            args_q         <= argument_data;
            argument_ready <= 1'b0;
            acc            <= '0;
            idx            <= '0;
            state          <= FWD;
          end else begin
            argument_ready <= 1'b1;
          end
        end
        FWD: begin
          if (idx == IDX_W'(N)) begin
            result_data  <= res_c;
            result_valid <= 1'b1;
`ifdef NEURON_MAC_RELU_EN
            pre_q        <= pre_c;
`endif
            idx          <= '0;
            state        <= RES;
          end else begin
            if (idx != '0) acc <= acc + ACC_W'(mul_p);
            idx <= idx + IDX_W'(1);
          end
        end
        RES: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (train) begin
              error_ready <= 1'b1;
              state       <= ERR;
            end else begin
              argument_ready <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        ERR: begin
          if (error_valid) begin
`ifdef NEURON_MAC_RELU_EN
            err_q <= (pre_q[W-1] || pre_q == '0) ? '0 : error_data;
`else
            err_q <= error_data;
`endif
            error_ready <= 1'b0;
            idx         <= '0;
            state       <= BWD;
          end
        end
        BWD: begin
          for (int i = 0; i < N; i++) begin
            if (idx == IDX_W'(2 * i + 1))
              prop_q[i] <= W'(sat(calc_t'(mul_p) >>> A, W));
            if (idx == IDX_W'(2 * i + 2))
              w[i] <= W'(sat(calc_t'(w[i]) + (calc_t'(mul_p) >>> (A + RATE)), W));
          end
          if (idx == IDX_W'(2 * N)) begin
            bias            <= W'(sat(calc_t'(bias) + (calc_t'(err_q) >>> RATE), W));
            propagate_valid <= 1'b1;
            idx             <= '0;
            state           <= PRP;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        PRP: begin
          if (propagate_ready) begin
            propagate_valid <= 1'b0;
            argument_ready  <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac (N=2, A=8, W=16)
module tb_neuron_mac;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               train = 1'b0;
  logic               argument_valid = 1'b0;
  logic               argument_ready;
  logic [15:0]        argument_data = '0;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic signed [15:0] result_data;
  logic               error_valid = 1'b0;
  logic               error_ready;
  logic signed [15:0] error_data = '0;
  logic               propagate_valid;
  logic               propagate_ready = 1'b0;
  logic [31:0]        propagate_data;

  int n_cmp = 0;
  int n_err = 0;

  neuron_mac #(.N(2), .A(8), .W(16), .RATE(0), .SEED(0)) dut (
    .clock           (clock),
    .reset           (reset),
    .train           (train),
    .argument_valid  (argument_valid),
    .argument_ready  (argument_ready),
    .argument_data   (argument_data),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_data     (result_data),
    .error_valid     (error_valid),
    .error_ready     (error_ready),
    .error_data      (error_data),
    .propagate_valid (propagate_valid),
    .propagate_ready (propagate_ready),
    .propagate_data  (propagate_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_params(input string tag, input logic [15:0] w1, input logic [15:0] w0,
                              input logic [15:0] b);
    check({tag, "_w1"}, $unsigned(dut.w[1]), w1);
    check({tag, "_w0"}, $unsigned(dut.w[0]), w0);
    check({tag, "_bias"}, $unsigned(dut.bias), b);
  endtask

  task automatic send_args(input string tag, input logic [15:0] args, input logic tr);
    int t = 0;
    while (!argument_ready && t < 20) begin step(); t++; end
    check({tag, "_arg_ready"}, argument_ready, 1);
    argument_data  = args;
    argument_valid = 1'b1;
    train          = tr;
    step();
    argument_valid = 1'b0;
  endtask

  task automatic forward(input string tag, input logic [15:0] args, input logic tr,
                         input logic [15:0] exp_res);
    send_args(tag, args, tr);
    step();
    step();
    check({tag, "_not_early"}, result_valid, 0);
    step();
    check({tag, "_valid"}, result_valid, 1);
    check({tag, "_result"}, $unsigned(result_data), exp_res);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check({tag, "_res_drop"}, result_valid, 0);
  endtask

  task automatic send_error(input string tag, input logic [15:0] err);
    int t = 0;
    while (!error_ready && t < 20) begin step(); t++; end
    check({tag, "_err_ready"}, error_ready, 1);
    error_data  = err;
    error_valid = 1'b1;
    step();
    error_valid = 1'b0;
  endtask

  task automatic wait_prop(input string tag);
    int t = 0;
    while (!propagate_valid && t < 40) begin step(); t++; end
    check({tag, "_prop_valid"}, propagate_valid, 1);
  endtask

  task automatic backprop(input string tag, input logic [15:0] err, input logic [31:0] exp_prop);
    send_error(tag, err);
    wait_prop(tag);
    check({tag, "_prop_data"}, propagate_data, exp_prop);
    propagate_ready = 1'b1;
    step();
    propagate_ready = 1'b0;
    check({tag, "_prop_drop"}, propagate_valid, 0);
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check("rst_res_valid", result_valid, 0);
    check("rst_err_ready", error_ready, 0);
    check("rst_prop_valid", propagate_valid, 0);
    reset = 1'b1;
    step();
    check("rel_arg_ready", argument_ready, 1);
    check("rel_result", $unsigned(result_data), 16'h0000);
    check("rel_prop", propagate_data, 32'h0);
    check_params("rel", 16'h0000, 16'h0000, 16'h0000);

    // inference only: zero weights, no backward
    forward("inf0", 16'hff80, 1'b0, 16'h0000);
    check("inf0_no_err_ready", error_ready, 0);
    check("inf0_idle_ready", argument_ready, 1);

    // first training step from zero weights
    forward("trn1", 16'hff80, 1'b1, 16'h0000);
    backprop("trn1", 16'h0100, 32'h0000_0000);
    check_params("trn1", 16'h00ff, 16'h0080, 16'h0100);

    // trained forward and propagate of old weights
    forward("trn2", 16'hff80, 1'b1, 16'h023e);
    backprop("trn2", 16'h0100, 32'h00ff_0080);
    check_params("trn2", 16'h01fe, 16'h0100, 16'h0200);

    // result back-pressure: 0x1fe*1 + 0x100*1 = 0x2fe >>> 8 = 2, plus bias 0x200
    send_args("stall_res", 16'h0101, 1'b0);
    argument_data  = 16'h5555;
    argument_valid = 1'b1;
    step();
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      check("stall_res_valid", result_valid, 1);
      check("stall_res_data", $unsigned(result_data), 16'h0202);
      check("stall_res_no_arg", argument_ready, 0);
      step();
    end
    argument_valid = 1'b0;
    result_ready   = 1'b1;
    step();
    result_ready   = 1'b0;
    check("stall_res_drop", result_valid, 0);

    // propagate back-pressure: zero args keep weights, bias gains the error
    forward("stall_prp", 16'h0000, 1'b1, 16'h0200);
    send_error("stall_prp", 16'h0100);
    wait_prop("stall_prp");
    for (int c = 0; c < 10; c++) begin
      check("stall_prp_valid", propagate_valid, 1);
      check("stall_prp_data", propagate_data, 32'h01fe_0100);
      check("stall_prp_no_arg", argument_ready, 0);
      step();
    end
    propagate_ready = 1'b1;
    step();
    propagate_ready = 1'b0;
    check("stall_prp_drop", propagate_valid, 0);
    check_params("stall_prp", 16'h01fe, 16'h0100, 16'h0300);

    // zero error: 0xff*0x1fe + 0x80*0x100 = 162818 >>> 8 = 0x27c, plus 0x300
    forward("zero_err", 16'hff80, 1'b1, 16'h057c);
    backprop("zero_err", 16'h0000, 32'h0000_0000);
    check_params("zero_err", 16'h01fe, 16'h0100, 16'h0300);

    // reset in the middle of the backward pass
    forward("mid_rst", 16'hff80, 1'b1, 16'h057c);
    send_error("mid_rst", 16'h0100);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_prop_valid", propagate_valid, 0);
    check("mid_rst_res_valid", result_valid, 0);
    check("mid_rst_err_ready", error_ready, 0);
    check("mid_rst_arg_ready", argument_ready, 0);
    check_params("mid_rst", 16'h0000, 16'h0000, 16'h0000);
    step();
    step();
    reset = 1'b1;
    step();
    forward("post_rst", 16'hff80, 1'b0, 16'h0000);

    // saturation: (0x7fff*0xff)>>>8 = 0x7f7f, then clamps at 0x7fff
    forward("sat1", 16'hffff, 1'b1, 16'h0000);
    backprop("sat1", 16'h7fff, 32'h0000_0000);
    check_params("sat1", 16'h7f7f, 16'h7f7f, 16'h7fff);
    forward("sat2", 16'hffff, 1'b1, 16'h7fff);
    backprop("sat2", 16'h7fff, 32'h7fff_7fff);
    check_params("sat2", 16'h7fff, 16'h7fff, 16'h7fff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
